// File: rtl/byte_word_pkg.sv
// Shared types and constants for the byte-to-word RAM loader.
package byte_word_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/byte_word_sequencer_if.sv
// Bundle of the loader's control, byte-stream and RAM-write signals.
// Byte handshake: a byte moves on a rising clock edge where byte_valid and
// byte_ready are both high; the source holds byte_data stable while
// byte_valid is high and the byte has not moved yet.
interface byte_word_sequencer_if import byte_word_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic                  start;
  logic [ADDR_W-1:0]     word_count;
  logic [ADDR_W-1:0]     base_addr;
  logic                  abort;
  logic [BYTE_W-1:0]     byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W_DEF-1:0] ram_data;
  logic                  ram_we;
  logic                  busy;
  logic                  done;

  // Requester side: issues loads and supplies bytes.
  modport master (
    output start, word_count, base_addr, abort, byte_data, byte_valid,
    input  byte_ready, ram_addr, ram_data, ram_we, busy, done
  );

  // Loader side.
  modport slave (
    input  start, word_count, base_addr, abort, byte_data, byte_valid,
    output byte_ready, ram_addr, ram_data, ram_we, busy, done
  );
endinterface

// File: rtl/byte_pair_register.sv
// 16-bit holding register built from two independently written bytes.
module byte_pair_register import byte_word_pkg::*; (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [BYTE_W-1:0]     byte_i,
  input  logic                  we_lo_i,
  input  logic                  we_hi_i,
  output logic [2*BYTE_W-1:0]   word_o
);
  logic [BYTE_W-1:0] lo_q;
  logic [BYTE_W-1:0] hi_q;

  // Capture each byte lane only when its own enable is set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if (we_lo_i) lo_q <= byte_i;
      if (we_hi_i) hi_q <= byte_i;
    end
  end

  assign word_o = {hi_q, lo_q};
endmodule

// File: rtl/byte_word_sequencer.sv
// Assembles little-endian byte pairs into words and writes them to
// consecutive RAM addresses, three cycles per word at full rate.
module byte_word_sequencer import byte_word_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] word_count_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              abort_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_we_o,
  output logic              busy_o,
  output logic              done_o,
  output state_e            dbg_state_o
);
  state_e            state_q;
  logic              ready_q;
  logic              we_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] last_q;
  logic [DATA_W-1:0] word_d;
  logic              xfer_d;
  logic              we_lo_d;
  logic              we_hi_d;

  // A byte is consumed only if no abort arrives in the same cycle.
  assign xfer_d  = byte_valid_i & ready_q & ~abort_i;
  assign we_lo_d = xfer_d & (state_q == ST_LOW);
  assign we_hi_d = xfer_d & (state_q == ST_HIGH);

  byte_pair_register u_pair (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .byte_i  (byte_i),
    .we_lo_i (we_lo_d),
    .we_hi_i (we_hi_d),
    .word_o  (word_d)
  );

  // Sequencer FSM; strobes and ready are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort_i && state_q != ST_IDLE) begin
        state_q <= ST_IDLE;
        ready_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              if (word_count_i != '0) begin
                cnt_q   <= word_count_i;
                addr_q  <= base_addr_i;
                state_q <= ST_LOW;
                ready_q <= 1'b1;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          ST_LOW: begin
            if (xfer_d) state_q <= ST_HIGH;
          end
          ST_HIGH: begin
            if (xfer_d) begin
              state_q <= ST_WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
            end
          end
          ST_WRITE: begin
            last_q <= word_d;
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - ADDR_W'(1);
            if (cnt_q == ADDR_W'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOW;
              ready_q <= 1'b1;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // An abort landing on the WRITE or DONE cycle suppresses that strobe.
  assign ram_we_o     = we_q & ~abort_i;
  assign done_o       = done_q & ~abort_i;
  assign byte_ready_o = ready_q;
  assign ram_addr_o   = addr_q;
  // The assembled word is shown only while writing; otherwise the last one.
  assign ram_data_o   = (state_q == ST_WRITE) ? word_d : last_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_byte_word_sequencer.sv
// Randomised scoreboard bench for byte_word_sequencer.
module tb_byte_word_sequencer;
  import byte_word_pkg::*;

  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_word_sequencer_if #(.ADDR_W(AW)) bus ();
  state_e dbg_state;

  byte_word_sequencer #(.ADDR_W(AW), .DATA_W(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (bus.start),
    .word_count_i (bus.word_count),
    .base_addr_i  (bus.base_addr),
    .abort_i      (bus.abort),
    .byte_i       (bus.byte_data),
    .byte_valid_i (bus.byte_valid),
    .byte_ready_o (bus.byte_ready),
    .ram_addr_o   (bus.ram_addr),
    .ram_data_o   (bus.ram_data),
    .ram_we_o     (bus.ram_we),
    .busy_o       (bus.busy),
    .done_o       (bus.done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [25:0] exp_q[$];     // {addr[9:0], data[15:0]}
  int          exp_done = 0;
  logic [15:0] last_data = '0;
  bit          ready_must_be_low = 1'b0;
  bit          job_has_words = 1'b0;
  bit          prev_done = 1'b0;
  int          cyc = 0;
  int          last_write_cyc = 0;
  logic [7:0]  fixed_bytes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [25:0] e;
    cyc++;
    if (!rst_n) begin
      last_data = '0;
      prev_done = 1'b0;
    end else begin
      if (bus.ram_we) begin
        if (exp_q.size() == 0) check("stray_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(bus.ram_addr), 32'(e[25:16]));
          check("write_data", 32'(bus.ram_data), 32'(e[15:0]));
          last_data = e[15:0];
        end
        last_write_cyc = cyc;
      end else begin
        check("data_hold", 32'(bus.ram_data), 32'(last_data));
      end
      if (bus.done) begin
        if (exp_done == 0) check("stray_done", 1, 0);
        else begin
          exp_done--;
          check("done_one_cycle", 32'(prev_done), 0);
          if (job_has_words) check("done_after_write", 32'(cyc - last_write_cyc), 1);
        end
      end
      prev_done = bus.done;
      if (ready_must_be_low && bus.byte_ready) check("ready_low", 1, 0);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] next_byte();
    if (fixed_bytes.size() != 0) return fixed_bytes.pop_front();
    return 8'($urandom);
  endfunction

  task automatic start_job(input int cnt, input int base);
    @(negedge clk);
    bus.start = 1'b1;
    bus.word_count = AW'(cnt);
    bus.base_addr = AW'(base);
    job_has_words = (cnt != 0);
    @(posedge clk);
    if (cnt == 0) exp_done++;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns just after the posedge on which the byte moved.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
    int waited = 0;
    for (int k = 0; k < gap; k++) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.byte_data = 8'($urandom);
      bus.start = pulse_start && (k == 0);
      bus.word_count = AW'($urandom);
      bus.base_addr = AW'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    while (!bus.byte_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.byte_ready) check("byte_accept_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic do_abort();
    int waited = 0;
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'($urandom);
    while (!bus.byte_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.byte_ready) check("abort_ready_timeout", 0, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_not_busy", 32'(bus.busy), 0);
    bus.abort = 1'b0;
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    while (bus.busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("idle_reached", 32'(bus.busy), 0);
  endtask

  // Reference: word i = {second byte, first byte} at (base + i) mod 1024.
  task automatic run_job(input int cnt, input int base, input int gap,
                         input int abort_at, input bit pulse_start);
    logic [7:0] lo, hi;
    int a;
    start_job(cnt, base);
    for (int i = 0; i < cnt; i++) begin
      if (abort_at == 2 * i) begin do_abort(); return; end
      lo = next_byte();
      send_byte(lo, gap, pulse_start);
      if (abort_at == 2 * i + 1) begin do_abort(); return; end
      hi = next_byte();
      send_byte(hi, gap, pulse_start);
      a = (base + i) % 1024;
      exp_q.push_back({a[9:0], hi, lo});
      if (i == cnt - 1) exp_done++;
    end
    wait_idle();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt, base, ab;
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.base_addr = '0;
    bus.abort = 1'b0;
    bus.byte_data = '0;
    bus.byte_valid = 1'b0;

    #1;
    check("rst_ready", 32'(bus.byte_ready), 0);
    check("rst_we", 32'(bus.ram_we), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_addr", 32'(bus.ram_addr), 0);
    check("rst_data", 32'(bus.ram_data), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Two words back-to-back.
    fixed_bytes = '{8'h34, 8'h12, 8'h78, 8'h56};
    run_job(2, 'h010, 0, -1, 1'b0);

    // Zero-length load: done only, ready stays low.
    ready_must_be_low = 1'b1;
    run_job(0, 'h123, 0, -1, 1'b0);
    ready_must_be_low = 1'b0;

    // Address wrap.
    run_job(2, 'h3FF, 0, -1, 1'b0);

    // Abort with the high byte presented, then a fresh load.
    run_job(2, 'h200, 0, 1, 1'b0);
    run_job(1, 'h100, 0, -1, 1'b0);

    // Abort in IDLE has no effect.
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    check("idle_abort_state", 32'(dbg_state), 32'(ST_IDLE));
    bus.abort = 1'b0;

    // Slow source with stray start pulses mid-load.
    fixed_bytes = '{8'h34, 8'h12, 8'h78, 8'h56};
    run_job(2, 'h010, 5, -1, 1'b1);

    // Reset while in HIGH.
    start_job(2, 'h050);
    send_byte(8'hAA, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.byte_ready), 0);
    check("mid_rst_we", 32'(bus.ram_we), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_addr", 32'(bus.ram_addr), 0);
    check("mid_rst_data", 32'(bus.ram_data), 0);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Randomised loads.
    for (int j = 0; j < 40; j++) begin
      cnt = $urandom_range(1, 4);
      base = ($urandom_range(0, 3) == 0) ? (1023 - $urandom_range(0, 2)) : $urandom_range(0, 1023);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * cnt - 1) : -1;
      run_job(cnt, base, $urandom_range(0, 3), ab, $urandom_range(0, 1));
    end

    repeat (4) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 0);
    check("pending_done", 32'(exp_done), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
